video_sync_normalize: RTL and testbench
=======================================

VIDEO_SYNC_NORMALIZE -- requirements
Module: video_sync_normalize

Interface
REQ-001 Parameters SHALL be: COLOR_DEPTH, default 6, bits per colour; HSCNT_WIDTH, default 12, pixel counter width; VSCNT_WIDTH, default 11, line counter width.
REQ-002 clk_sys  in  1  system clock; all logic SHALL be on its rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 pixel_ena  in  1  pixel strobe from scandoubler; all state SHALL advance only when high.
REQ-005 hb_in, vb_in, hs_in, vs_in  in  1 each  scandoubled blanking/sync, either sync polarity.
REQ-006 r_in, g_in, b_in  in  COLOR_DEPTH each  scandoubled colour.
REQ-007 hb_out, vb_out, hs_out, vs_out  out  1 each  registered blanking, sync normalised active-high.
REQ-008 r_out, g_out, b_out  out  COLOR_DEPTH each  registered colour, zero while blanked.
REQ-009 de_out  out  1  data enable = !(hb_out|vb_out).
REQ-010 hs_pol, vs_pol  out  1 each  detected input polarity, 1 = active-high.
REQ-011 h_active  out  HSCNT_WIDTH  active pixels per line; v_active  out  VSCNT_WIDTH  active lines per frame.
REQ-012 measure_valid  out  1  resolution stable.

Function
REQ-013 Data path SHALL have latency exactly one pixel_ena strobe; outputs SHALL hold between strobes.
REQ-014 hs_out SHALL equal hs_in XNOR hs_pol, sampled at the strobe; vs_out likewise with vs_pol.
REQ-015 Line period SHALL be strobes between consecutive hs_in rising edges; hs_high SHALL count strobes with hs_in=1 in that period.
REQ-016 At each hs_in rising edge, hs_pol SHALL become 1 if 2*hs_high < period, else 0, taking effect the next strobe.
REQ-017 vs_pol SHALL use the same rule over lines between vs_in rising edges, counting lines (hs_in rising edges) rather than strobes.
REQ-018 Counters SHALL saturate at all-ones; a saturated period SHALL leave the corresponding polarity unchanged.
REQ-019 Per line, active count SHALL increment on strobes with hb_in=0 and vb_in=0; at the normalised hsync rising edge, a nonzero count SHALL be latched to a line-width register and v-count incremented.
REQ-020 At the normalised vsync rising edge, h_active/v_active SHALL update from latched width and v-count; v-count SHALL clear.
REQ-021 measure_valid SHALL set when two consecutive frame updates give identical h_active and v_active, and clear on the first differing update.
REQ-022 Simultaneous hsync and vsync edges SHALL close the line first, so the frame includes that line.
REQ-023 With pixel_ena held low, no output or counter SHALL change.

Reset
REQ-024 Reset SHALL force outputs to zero, except hs_pol=vs_pol=1 and hs_out=vs_out=0.
REQ-025 Reset SHALL clear all counters, latches and measure_valid; reset mid-frame SHALL discard the partial measurement.
REQ-026 After reset release, first polarity decision SHALL occur at the second hs_in rising edge.

Configuration
REQ-027 Macro VIDEO_SYNC_MEASURE_EN SHALL compile in REQ-019 to REQ-021.
REQ-028 Without VIDEO_SYNC_MEASURE_EN, h_active, v_active and measure_valid SHALL be constant 0, with no measurement registers; data path and polarity logic are unchanged.

Structure
REQ-029 Shared package video_pkg SHALL hold default widths and a sync-polarity typedef (active-low=0, active-high=1).
REQ-030 One sub-module, sync_polarity_detect, SHALL be instantiated twice (horizontal, vertical), with its count-enable as an input.

Verification
REQ-031 800-strobe line, hs_in low for 96 strobes -> hs_pol=0 after second edge; hs_out high for 96 strobes per line.
REQ-032 Same timing with hs_in high for 96 strobes -> hs_pol=1; hs_out identical to hs_in delayed one strobe.
REQ-033 Two 640x480 frames, hb/vb framed -> h_active=640, v_active=480, measure_valid=1 after second vsync edge.
REQ-034 Third frame 320x240 -> measure_valid=0 at that vsync edge, values 320/240; fourth identical frame -> measure_valid=1.
REQ-035 pixel_ena every 4th clk_sys, reset asserted mid-line -> all outputs per REQ-024 immediately, not waiting for clk_sys.
REQ-036 hs_in stuck high for more than 4096 strobes -> counter saturates, hs_pol unchanged.

Source files
------------

// File: rtl/video_pkg.sv
// ============================================================================
// Module      : video_pkg
// Description : Shared definitions for the video sync normaliser: default
//               port widths, the sync polarity type and the duty-cycle rule
//               that turns a measured sync period into a polarity.
//               Used by video_sync_normalize, its interface and
//               sync_polarity_detect.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package video_pkg;

    localparam int DEF_COLOR_DEPTH = 6;
    localparam int DEF_HSCNT_WIDTH = 12;
    localparam int DEF_VSCNT_WIDTH = 11;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // A sync pulse is the short part of its period: if the high time is
    // less than half the period the pulse is high, otherwise it is low.
    function automatic sync_pol_e pol_from_duty(input int unsigned high,
                                                input int unsigned period);
        return ((high << 1) < period) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
    endfunction

endpackage

`default_nettype wire

// File: rtl/video_sync_normalize_if.sv
// ============================================================================
// Module      : video_sync_normalize_if
// Description : Video bus of the sync normaliser: scandoubled video in,
//               registered normalised video, detected polarities and
//               resolution measurement out. master = video source/sink,
//               slave = normaliser.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface video_sync_normalize_if
    import video_pkg::*;
#(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int HSCNT_WIDTH = DEF_HSCNT_WIDTH,
    parameter int VSCNT_WIDTH = DEF_VSCNT_WIDTH
);

    logic                   pixel_ena;
    logic                   hb_in;
    logic                   vb_in;
    logic                   hs_in;
    logic                   vs_in;
    logic [COLOR_DEPTH-1:0] r_in;
    logic [COLOR_DEPTH-1:0] g_in;
    logic [COLOR_DEPTH-1:0] b_in;

    logic                   hb_out;
    logic                   vb_out;
    logic                   hs_out;
    logic                   vs_out;
    logic [COLOR_DEPTH-1:0] r_out;
    logic [COLOR_DEPTH-1:0] g_out;
    logic [COLOR_DEPTH-1:0] b_out;
    logic                   de_out;
    logic                   hs_pol;
    logic                   vs_pol;
    logic [HSCNT_WIDTH-1:0] h_active;
    logic [VSCNT_WIDTH-1:0] v_active;
    logic                   measure_valid;

    modport master (
        output pixel_ena, hb_in, vb_in, hs_in, vs_in, r_in, g_in, b_in,
        input  hb_out, vb_out, hs_out, vs_out, r_out, g_out, b_out, de_out,
        input  hs_pol, vs_pol, h_active, v_active, measure_valid
    );

    modport slave (
        input  pixel_ena, hb_in, vb_in, hs_in, vs_in, r_in, g_in, b_in,
        output hb_out, vb_out, hs_out, vs_out, r_out, g_out, b_out, de_out,
        output hs_pol, vs_pol, h_active, v_active, measure_valid
    );

endinterface

`default_nettype wire

// File: rtl/sync_polarity_detect.sv
// ============================================================================
// Module      : sync_polarity_detect
// Description : Measures one sync signal between consecutive rising edges
//               (period and time spent high, in units of cnt_en) and decides
//               its polarity at each rising edge. Saturated counts keep the
//               previous decision. The first edge after reset only starts a
//               measurement. Also exports the rising-edge strobe.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_polarity_detect
    import video_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_HSCNT_WIDTH
) (
    input  wire logic clk_sys,
    input  wire logic reset,
    input  wire logic ena,
    input  wire logic cnt_en,
    input  wire logic sync_in,
    output sync_pol_e pol,
    output logic      sync_rise
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

    logic                 prev_q,   prev_d;
    logic                 seen_q,   seen_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q,   high_d;
    sync_pol_e            pol_q,    pol_d;

    assign sync_rise = ena & sync_in & ~prev_q;
    assign pol       = pol_q;

    // Edge detect, period/high counting and the polarity decision.
    always_comb begin
        prev_d   = prev_q;
        seen_d   = seen_q;
        period_d = period_q;
        high_d   = high_q;
        pol_d    = pol_q;
        if (ena) begin
            prev_d = sync_in;
            if (sync_rise) begin
                if (seen_q && (period_q != C_MAX)) begin
                    pol_d = pol_from_duty(32'(high_q), 32'(period_q));
                end
                seen_d = 1'b1;
                // The edge strobe itself is the first unit of the new period.
                period_d = cnt_en ? C_ONE : '0;
                high_d   = cnt_en ? C_ONE : '0;
            end else if (cnt_en) begin
                if (period_q != C_MAX) begin
                    period_d = period_q + C_ONE;
                end
                if (sync_in && (high_q != C_MAX)) begin
                    high_d = high_q + C_ONE;
                end
            end
        end
    end

    // State register; polarity resets to active-high.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prev_q   <= 1'b0;
            seen_q   <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            pol_q    <= SYNC_ACTIVE_HIGH;
        end else begin
            prev_q   <= prev_d;
            seen_q   <= seen_d;
            period_q <= period_d;
            high_q   <= high_d;
            pol_q    <= pol_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_sync_normalize.sv
// ============================================================================
// Module      : video_sync_normalize
// Description : Registers scandoubled video on each pixel strobe, blanks the
//               colour outside the active area and normalises hsync/vsync to
//               active-high using detected input polarities. Optional
//               resolution measurement (active pixels per line, active lines
//               per frame, stability flag) is built when the macro
//               VIDEO_SYNC_MEASURE_EN is defined; otherwise those outputs
//               are tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module video_sync_normalize
    import video_pkg::*;
#(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int HSCNT_WIDTH = DEF_HSCNT_WIDTH,
    parameter int VSCNT_WIDTH = DEF_VSCNT_WIDTH
) (
    input wire logic               clk_sys,
    input wire logic               reset,
    video_sync_normalize_if.slave  vif
);

    sync_pol_e              hs_pol_e;
    sync_pol_e              vs_pol_e;
    logic                   hs_pol_l;
    logic                   vs_pol_l;
    logic                   h_rise;
    logic                   v_rise_unused;
    logic                   blank;

    logic                   hb_q, hb_d;
    logic                   vb_q, vb_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   de_q, de_d;
    logic [COLOR_DEPTH-1:0] r_q,  r_d;
    logic [COLOR_DEPTH-1:0] g_q,  g_d;
    logic [COLOR_DEPTH-1:0] b_q,  b_d;

    // Horizontal polarity counts strobes between hsync edges.
    sync_polarity_detect #(
        .CNT_WIDTH (HSCNT_WIDTH)
    ) u_h_pol (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ena       (vif.pixel_ena),
        .cnt_en    (1'b1),
        .sync_in   (vif.hs_in),
        .pol       (hs_pol_e),
        .sync_rise (h_rise)
    );

    // Vertical polarity counts lines (hsync edges) between vsync edges.
    sync_polarity_detect #(
        .CNT_WIDTH (VSCNT_WIDTH)
    ) u_v_pol (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ena       (vif.pixel_ena),
        .cnt_en    (h_rise),
        .sync_in   (vif.vs_in),
        .pol       (vs_pol_e),
        .sync_rise (v_rise_unused)
    );

    assign hs_pol_l = hs_pol_e;
    assign vs_pol_l = vs_pol_e;
    assign blank    = vif.hb_in | vif.vb_in;

    // Data path: capture on the strobe, hold otherwise. Sync uses the
    // polarity in force before this strobe's own decision.
    always_comb begin
        hb_d = hb_q;
        vb_d = vb_q;
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        if (vif.pixel_ena) begin
            hb_d = vif.hb_in;
            vb_d = vif.vb_in;
            hs_d = vif.hs_in ~^ hs_pol_l;
            vs_d = vif.vs_in ~^ vs_pol_l;
            de_d = ~blank;
            r_d  = blank ? '0 : vif.r_in;
            g_d  = blank ? '0 : vif.g_in;
            b_d  = blank ? '0 : vif.b_in;
        end
    end

    // Output registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hb_q <= 1'b0;
            vb_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
        end else begin
            hb_q <= hb_d;
            vb_q <= vb_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
        end
    end

    assign vif.hb_out = hb_q;
    assign vif.vb_out = vb_q;
    assign vif.hs_out = hs_q;
    assign vif.vs_out = vs_q;
    assign vif.de_out = de_q;
    assign vif.r_out  = r_q;
    assign vif.g_out  = g_q;
    assign vif.b_out  = b_q;
    assign vif.hs_pol = hs_pol_l;
    assign vif.vs_pol = vs_pol_l;

`ifdef VIDEO_SYNC_MEASURE_EN

    localparam logic [HSCNT_WIDTH-1:0] C_H_ONE = HSCNT_WIDTH'(1);
    localparam logic [VSCNT_WIDTH-1:0] C_V_ONE = VSCNT_WIDTH'(1);

    logic                   h_nrise;
    logic                   v_nrise;
    logic [HSCNT_WIDTH-1:0] frame_h;
    logic [VSCNT_WIDTH-1:0] frame_v;
    logic [HSCNT_WIDTH-1:0] act_cnt_q,    act_cnt_d;
    logic [HSCNT_WIDTH-1:0] line_w_q,     line_w_d;
    logic [HSCNT_WIDTH-1:0] h_act_q,      h_act_d;
    logic [VSCNT_WIDTH-1:0] v_cnt_q,      v_cnt_d;
    logic [VSCNT_WIDTH-1:0] v_act_q,      v_act_d;
    logic                   valid_q,      valid_d;
    logic                   frame_seen_q, frame_seen_d;

    // Rising edges of the normalised syncs: next registered value high
    // while the current registered value is low.
    assign h_nrise = vif.pixel_ena & hs_d & ~hs_q;
    assign v_nrise = vif.pixel_ena & vs_d & ~vs_q;

    // Line closes before frame so a coincident hsync edge lands in the frame.
    always_comb begin
        act_cnt_d    = act_cnt_q;
        line_w_d     = line_w_q;
        h_act_d      = h_act_q;
        v_cnt_d      = v_cnt_q;
        v_act_d      = v_act_q;
        valid_d      = valid_q;
        frame_seen_d = frame_seen_q;
        frame_h      = line_w_q;
        frame_v      = v_cnt_q;
        if (vif.pixel_ena) begin
            if (h_nrise) begin
                if (act_cnt_q != '0) begin
                    line_w_d = act_cnt_q;
                    if (v_cnt_q != '1) begin
                        v_cnt_d = v_cnt_q + C_V_ONE;
                    end
                end
                act_cnt_d = blank ? '0 : C_H_ONE;
            end else if (!blank && (act_cnt_q != '1)) begin
                act_cnt_d = act_cnt_q + C_H_ONE;
            end
            if (v_nrise) begin
                frame_h      = line_w_d;
                frame_v      = v_cnt_d;
                h_act_d      = frame_h;
                v_act_d      = frame_v;
                valid_d      = frame_seen_q && (frame_h == h_act_q)
                                            && (frame_v == v_act_q);
                frame_seen_d = 1'b1;
                v_cnt_d      = '0;
            end
        end
    end

    // Measurement registers; reset discards any partial frame.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            act_cnt_q    <= '0;
            line_w_q     <= '0;
            h_act_q      <= '0;
            v_cnt_q      <= '0;
            v_act_q      <= '0;
            valid_q      <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            act_cnt_q    <= act_cnt_d;
            line_w_q     <= line_w_d;
            h_act_q      <= h_act_d;
            v_cnt_q      <= v_cnt_d;
            v_act_q      <= v_act_d;
            valid_q      <= valid_d;
            frame_seen_q <= frame_seen_d;
        end
    end

    assign vif.h_active      = h_act_q;
    assign vif.v_active      = v_act_q;
    assign vif.measure_valid = valid_q;

`else

    assign vif.h_active      = '0;
    assign vif.v_active      = '0;
    assign vif.measure_valid = 1'b0;

`endif

endmodule

`default_nettype wire

// File: tb/tb_video_sync_normalize.sv
// ============================================================================
// Module      : tb_video_sync_normalize
// Description : Self-checking bench for video_sync_normalize. Drives
//               randomised colour and strobe spacing over directed sync
//               timings and compares every clock against a behavioural
//               model built from sample histories.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_video_sync_normalize;

    localparam int CD = 6;
    localparam int HW = 12;
    localparam int VW = 11;

    logic clk_sys;
    logic reset;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    video_sync_normalize_if #(.COLOR_DEPTH(CD), .HSCNT_WIDTH(HW), .VSCNT_WIDTH(VW)) vif ();

    video_sync_normalize #(
        .COLOR_DEPTH (CD),
        .HSCNT_WIDTH (HW),
        .VSCNT_WIDTH (VW)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .vif     (vif)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Model state: per-strobe histories since reset.
    bit      hs_h[$];
    bit      vs_h[$];
    bit      hr_h[$];
    int      h_last;
    int      v_last;
    logic    prev_hs, prev_vs;
    logic    m_hs_pol, m_vs_pol;
    logic    exp_hb, exp_vb, exp_hs, exp_vs, exp_de;
    logic [CD-1:0] exp_r, exp_g, exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s:%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hs_h.delete(); vs_h.delete(); hr_h.delete();
        h_last = -1; v_last = -1;
        prev_hs = 1'b0; prev_vs = 1'b0;
        m_hs_pol = 1'b1; m_vs_pol = 1'b1;
        exp_hb = 0; exp_vb = 0; exp_hs = 0; exp_vs = 0; exp_de = 0;
        exp_r = '0; exp_g = '0; exp_b = '0;
    endtask

    task automatic check_all();
        chk("hb_out", 32'(vif.hb_out), 32'(exp_hb));
        chk("vb_out", 32'(vif.vb_out), 32'(exp_vb));
        chk("hs_out", 32'(vif.hs_out), 32'(exp_hs));
        chk("vs_out", 32'(vif.vs_out), 32'(exp_vs));
        chk("de_out", 32'(vif.de_out), 32'(exp_de));
        chk("r_out",  32'(vif.r_out),  32'(exp_r));
        chk("g_out",  32'(vif.g_out),  32'(exp_g));
        chk("b_out",  32'(vif.b_out),  32'(exp_b));
        chk("hs_pol", 32'(vif.hs_pol), 32'(m_hs_pol));
        chk("vs_pol", 32'(vif.vs_pol), 32'(m_vs_pol));
`ifndef VIDEO_SYNC_MEASURE_EN
        chk("h_active",      32'(vif.h_active),      32'd0);
        chk("v_active",      32'(vif.v_active),      32'd0);
        chk("measure_valid", 32'(vif.measure_valid), 32'd0);
`endif
    endtask

    // One accepted strobe: outputs follow inputs, then polarity rules apply
    // to completed periods (line periods in strobes, frame periods in lines).
    task automatic model_step(input logic hb, vb, hs, vs, input logic [CD-1:0] r, g, b);
        int   t;
        int   period;
        int   high;
        logic hr;
        logic vr;
        t  = hs_h.size();
        hr = hs & ~prev_hs;
        vr = vs & ~prev_vs;
        exp_hb = hb; exp_vb = vb;
        exp_hs = ~(hs ^ m_hs_pol);
        exp_vs = ~(vs ^ m_vs_pol);
        exp_de = !(hb || vb);
        exp_r  = exp_de ? r : '0;
        exp_g  = exp_de ? g : '0;
        exp_b  = exp_de ? b : '0;
        hs_h.push_back(hs); vs_h.push_back(vs); hr_h.push_back(hr);
        if (hr) begin
            if (h_last >= 0) begin
                period = t - h_last;
                high   = 0;
                for (int i = h_last; i < t; i++) high += int'(hs_h[i]);
                if (period < 4095) m_hs_pol = (2 * high < period);
            end
            h_last = t;
        end
        if (vr) begin
            if (v_last >= 0) begin
                period = 0;
                high   = 0;
                for (int i = v_last; i < t; i++) begin
                    if (hr_h[i]) begin
                        period++;
                        if (vs_h[i]) high++;
                    end
                end
                if (period < 2047) m_vs_pol = (2 * high < period);
            end
            v_last = t;
        end
        prev_hs = hs;
        prev_vs = vs;
    endtask

    // Idle clocks carry random junk that must be ignored, then one strobe.
    task automatic pixel(input logic hb, vb, hs, vs, input int gmin, gmax);
        int            gap;
        logic [CD-1:0] r, g, b;
        gap = int'($urandom_range(gmax, gmin));
        for (int k = 0; k < gap; k++) begin
            vif.pixel_ena = 1'b0;
            vif.hb_in = 1'($urandom); vif.vb_in = 1'($urandom);
            vif.hs_in = 1'($urandom); vif.vs_in = 1'($urandom);
            vif.r_in = CD'($urandom); vif.g_in = CD'($urandom); vif.b_in = CD'($urandom);
            @(posedge clk_sys); #1;
            check_all();
        end
        r = CD'($urandom); g = CD'($urandom); b = CD'($urandom);
        vif.hb_in = hb; vif.vb_in = vb; vif.hs_in = hs; vif.vs_in = vs;
        vif.r_in = r; vif.g_in = g; vif.b_in = b;
        vif.pixel_ena = 1'b1;
        @(posedge clk_sys); #1;
        model_step(hb, vb, hs, vs, r, g, b);
        check_all();
        vif.pixel_ena = 1'b0;
    endtask

    task automatic video_line(input int len, h_act, input logic vblank, input int hs_start, hs_w,
                              input logic hs_hi, vs_lvl, input int gmin, gmax);
        logic pulse;
        for (int x = 0; x < len; x++) begin
            pulse = (x >= hs_start) && (x < hs_start + hs_w);
            pixel(x >= h_act, vblank, hs_hi ? pulse : !pulse, vs_lvl, gmin, gmax);
        end
    endtask

    task automatic video_frame(input int len, h_act, hs_start, hs_w, input logic hs_hi,
                               input int lines, v_act, vs_start, vs_w, input logic vs_hi,
                               input int gmin, gmax);
        logic pulse;
        for (int y = 0; y < lines; y++) begin
            pulse = (y >= vs_start) && (y < vs_start + vs_w);
            video_line(len, h_act, y >= v_act, hs_start, hs_w, hs_hi,
                       vs_hi ? pulse : !pulse, gmin, gmax);
        end
    endtask

    int  fh[4];
    int  fv[4];
    logic exp_valid;

    initial begin
        reset = 1'b1;
        vif.pixel_ena = 1'b0;
        vif.hb_in = 0; vif.vb_in = 0; vif.hs_in = 0; vif.vs_in = 0;
        vif.r_in = '0; vif.g_in = '0; vif.b_in = '0;
        model_reset();
        phase = "reset";
        repeat (3) @(posedge clk_sys);
        #1 check_all();
        @(negedge clk_sys) reset = 1'b0;

        // 800-strobe lines with a 96-strobe active-low hsync.
        phase = "hs_low";
        for (int l = 0; l < 3; l++) video_line(800, 640, 1'b0, 656, 96, 1'b0, 1'b0, 0, 1);
        chk("hs_pol_low", 32'(vif.hs_pol), 32'd0);

        // Same timing with an active-high hsync.
        phase = "hs_high";
        for (int l = 0; l < 3; l++) video_line(800, 640, 1'b0, 656, 96, 1'b1, 1'b0, 0, 1);
        chk("hs_pol_high", 32'(vif.hs_pol), 32'd1);

        // hsync stuck high well past counter saturation: polarity must hold.
        phase = "hs_stuck";
        for (int i = 0; i < 5000; i++) pixel(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int l = 0; l < 2; l++) video_line(800, 640, 1'b0, 656, 96, 1'b1, 1'b0, 0, 0);
        chk("hs_pol_sat", 32'(vif.hs_pol), 32'd1);

        // Short lines, 12-line frames with a 2-line active-low vsync.
        phase = "vs_low";
        for (int f = 0; f < 3; f++) video_frame(40, 30, 32, 4, 1'b1, 12, 8, 9, 2, 1'b0, 0, 2);
        chk("vs_pol_low", 32'(vif.vs_pol), 32'd0);

        // Asynchronous reset in the middle of a line, strobe every 4th clock.
        phase = "async_reset";
        for (int x = 0; x < 10; x++) pixel(1'b0, 1'b0, 1'b0, 1'b1, 3, 3);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys) reset = 1'b0;

        // Two frames of one geometry, then two of half the size.
        phase = "measure";
        fh[0] = 20; fh[1] = 20; fh[2] = 10; fh[3] = 10;
        fv[0] = 8;  fv[1] = 8;  fv[2] = 4;  fv[3] = 4;
        for (int k = 0; k < 4; k++) begin
            video_frame(28, fh[k], 22, 3, 1'b1, 12, fv[k], 9, 2, 1'b1, 0, 1);
            exp_valid = 1'b0;
            if (k > 0) exp_valid = (fh[k] == fh[k-1]) && (fv[k] == fv[k-1]);
`ifdef VIDEO_SYNC_MEASURE_EN
            chk("h_active_frame",      32'(vif.h_active),      32'(fh[k]));
            chk("v_active_frame",      32'(vif.v_active),      32'(fv[k]));
            chk("measure_valid_frame", 32'(vif.measure_valid), 32'(exp_valid));
`else
            chk("h_active_off",      32'(vif.h_active),      32'd0);
            chk("v_active_off",      32'(vif.v_active),      32'd0);
            chk("measure_valid_off", 32'(vif.measure_valid), 32'd0);
`endif
        end
        chk("hs_pol_meas", 32'(vif.hs_pol), 32'd1);
        chk("vs_pol_meas", 32'(vif.vs_pol), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
